// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// Rx is synchronised through two flops and each bit is decided by a 2-of-3
// majority vote around the bit centre. Data width, parity mode and stop-bit
// count are set by parameters. Good words are delivered on a valid/ready
// handshake. Framing, parity and overrun conditions are reported as
// single-cycle pulses.
module uart_rx_param #(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 enable,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF  = CYCLES_PER_BIT / 2;
    localparam int CNT_W = $clog2(CYCLES_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // 2-of-3 majority of the three mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity check of the received word against the received parity bit
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        case (PARITY)
            1:       return ~x;
            2:       return x;
            default: return 1'b1;
        endcase
    endfunction

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [3:0]           bit_idx_r;
    logic                 samp0_r;
    logic                 samp1_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 frame_bad_r;
    logic                 done_r;

    logic maj_s;
    logic dec_s;
    logic wrap_s;
    logic done_ok_s;
    logic par_ok_s;
    logic good_s;
    logic load_s;

    assign maj_s     = maj3(samp0_r, samp1_r, rx_sync_r);
    assign dec_s     = (cnt_r == CNT_DEC);
    assign wrap_s    = (cnt_r == CNT_LAST);
    assign done_ok_s = done_r & enable;
    assign par_ok_s  = parity_ok(shift_r, par_bit_r);
    assign good_s    = done_ok_s & ~frame_bad_r & par_ok_s;
    assign load_s    = good_s & (~data_valid | data_ready);
    assign busy      = (state_r != ST_IDLE);

    // Two-flop synchroniser for Rx plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!nRst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= Rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM: bit timing, mid-bit sampling, shifting and frame completion
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            bit_idx_r   <= 4'd0;
            samp0_r     <= 1'b1;
            samp1_r     <= 1'b1;
            shift_r     <= {DATA_BITS{1'b0}};
            par_bit_r   <= 1'b0;
            frame_bad_r <= 1'b0;
            done_r      <= 1'b0;
        end else if (!enable) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (cnt_r == CNT_S0) samp0_r <= rx_sync_r;
            if (cnt_r == CNT_S1) samp1_r <= rx_sync_r;
            if (state_r != ST_IDLE) cnt_r <= wrap_s ? CNT_ZERO : cnt_r + CNT_ONE;
            case (state_r)
                ST_IDLE: begin
                    if (!rx_sync_r && rx_prev_r) begin
                        state_r     <= ST_START;
                        cnt_r       <= CNT_ZERO;
                        frame_bad_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (dec_s && maj_s) begin
                        state_r <= ST_IDLE;
                    end else if (wrap_s) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= 4'd0;
                    end
                end
                ST_DATA: begin
                    if (dec_s) shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
                    if (wrap_s) begin
                        if (bit_idx_r == DATA_LAST) begin
                            bit_idx_r <= 4'd0;
                            state_r   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (dec_s) par_bit_r <= maj_s;
                    if (wrap_s) begin
                        state_r   <= ST_STOP;
                        bit_idx_r <= 4'd0;
                    end
                end
                ST_STOP: begin
                    if (wrap_s) bit_idx_r <= bit_idx_r + 4'd1;
                    if (dec_s) begin
                        if (!maj_s) frame_bad_r <= 1'b1;
                        // Leave on the last stop decision so a back-to-back start edge is seen
                        if (bit_idx_r == STOP_LAST) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output stage: error pulses, word buffer and valid/ready handshake
    always_ff @(posedge clk) begin
        if (!nRst) begin
            data_out      <= {DATA_BITS{1'b0}};
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= done_ok_s & frame_bad_r;
            parity_error  <= done_ok_s & ~frame_bad_r & ~par_ok_s;
            overrun       <= good_s & ~load_s;
            if (load_s) begin
                data_out   <= shift_r;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end else begin
                data_valid <= data_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param with three instances:
// 8N1 (index 0), 8E1 (index 1) and 7O2 (index 2), all at 16 cycles per bit.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk    = 1'b0;
    logic       nRst   = 1'b0;
    logic       enable = 1'b1;
    logic [2:0] rx     = 3'b111;
    logic [2:0] ready  = 3'b111;
    logic [2:0] dv;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] ov;
    logic [2:0] bsy;
    logic [7:0] dout_n;
    logic [7:0] dout_e;
    logic [6:0] dout_o;

    int checks = 0;
    int errors = 0;

    int pe_c[3];
    int fe_c[3];
    int ov_c[3];
    int rise_c[3];
    int vhi_c[3];
    int busy_c[3];
    int s_pe[3];
    int s_fe[3];
    int s_ov[3];
    int s_rise[3];
    int s_vhi[3];
    int s_busy[3];
    logic [2:0] dv_prev      = 3'b000;
    logic [2:0] busy_at_rise = 3'b000;

    always #5 clk = ~clk;

    uart_rx_param #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
        .clk(clk), .nRst(nRst), .enable(enable), .Rx(rx[0]),
        .data_out(dout_n), .data_valid(dv[0]), .data_ready(ready[0]),
        .parity_error(pe[0]), .framing_error(fe[0]), .overrun(ov[0]), .busy(bsy[0]));

    uart_rx_param #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e (
        .clk(clk), .nRst(nRst), .enable(enable), .Rx(rx[1]),
        .data_out(dout_e), .data_valid(dv[1]), .data_ready(ready[1]),
        .parity_error(pe[1]), .framing_error(fe[1]), .overrun(ov[1]), .busy(bsy[1]));

    uart_rx_param #(.CYCLES_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_o (
        .clk(clk), .nRst(nRst), .enable(enable), .Rx(rx[2]),
        .data_out(dout_o), .data_valid(dv[2]), .data_ready(ready[2]),
        .parity_error(pe[2]), .framing_error(fe[2]), .overrun(ov[2]), .busy(bsy[2]));

    // Event monitor: counts high cycles of each pulse/valid/busy and valid rises
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (pe[d])  pe_c[d]   <= pe_c[d] + 1;
            if (fe[d])  fe_c[d]   <= fe_c[d] + 1;
            if (ov[d])  ov_c[d]   <= ov_c[d] + 1;
            if (dv[d])  vhi_c[d]  <= vhi_c[d] + 1;
            if (bsy[d]) busy_c[d] <= busy_c[d] + 1;
            if (dv[d] && !dv_prev[d]) begin
                rise_c[d]       <= rise_c[d] + 1;
                busy_at_rise[d] <= bsy[d];
            end
            dv_prev[d] <= dv[d];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        for (int d = 0; d < 3; d++) begin
            s_pe[d]   = pe_c[d];
            s_fe[d]   = fe_c[d];
            s_ov[d]   = ov_c[d];
            s_rise[d] = rise_c[d];
            s_vhi[d]  = vhi_c[d];
            s_busy[d] = busy_c[d];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive n frame bits LSB first, CPB cycles each. gpos: frame bit that gets a
    // one-cycle inversion at its first-sample point. rpos: frame bit at whose
    // centre a one-cycle reset is applied and the frame abandoned.
    task automatic drive_frame(input int d, input logic [15:0] bits, input int n,
                               input int gpos, input int rpos);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < CPB; c++) begin
                if (p == rpos && c == 8) begin
                    nRst = 1'b0;
                    @(posedge clk);
                    #1;
                    check_eq("midrst_dv", 32'(dv[d]), 32'd0);
                    check_eq("midrst_dout", 32'(dout_o), 32'd0);
                    check_eq("midrst_busy", 32'(bsy[d]), 32'd0);
                    check_eq("midrst_pulses", 32'(pe[d] | fe[d] | ov[d]), 32'd0);
                    nRst  = 1'b1;
                    rx[d] = 1'b1;
                    return;
                end
                rx[d] = bits[p] ^ ((p == gpos && c == 8) ? 1'b1 : 1'b0);
                @(posedge clk);
                #1;
            end
        end
        rx[d] = 1'b1;
    endtask

    function automatic int err_delta(input int d);
        return (pe_c[d] - s_pe[d]) + (fe_c[d] - s_fe[d]) + (ov_c[d] - s_ov[d]);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        check_eq("rst_dv", 32'(dv), 32'd0);
        check_eq("rst_busy", 32'(bsy), 32'd0);
        check_eq("rst_pulses", 32'(pe | fe | ov), 32'd0);
        check_eq("rst_dout", 32'({dout_n, dout_e, dout_o}), 32'd0);
        nRst = 1'b1;
        idle(5);

        // 8N1 0xA5 with ready held high
        snap();
        drive_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1, -1);
        idle(20);
        check_eq("a5_rise", 32'(rise_c[0] - s_rise[0]), 32'd1);
        check_eq("a5_valid_cycles", 32'(vhi_c[0] - s_vhi[0]), 32'd1);
        check_eq("a5_data", 32'(dout_n), 32'h0000_00A5);
        check_eq("a5_errs", 32'(err_delta(0)), 32'd0);
        check_eq("a5_busy_cycles", 32'(busy_c[0] - s_busy[0]), 32'd154);
        check_eq("a5_busy_at_valid", 32'(busy_at_rise[0]), 32'd0);

        // 8E1 0x5A: wrong parity bit then correct one
        snap();
        drive_frame(1, 16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, -1, -1);
        idle(20);
        check_eq("par_bad_pe_cycles", 32'(pe_c[1] - s_pe[1]), 32'd1);
        check_eq("par_bad_rise", 32'(rise_c[1] - s_rise[1]), 32'd0);
        check_eq("par_bad_dv", 32'(dv[1]), 32'd0);
        snap();
        drive_frame(1, 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, -1, -1);
        idle(20);
        check_eq("par_ok_rise", 32'(rise_c[1] - s_rise[1]), 32'd1);
        check_eq("par_ok_data", 32'(dout_e), 32'h0000_005A);
        check_eq("par_ok_errs", 32'(err_delta(1)), 32'd0);

        // False start: 3 low cycles
        snap();
        rx[0] = 1'b0;
        idle(3);
        rx[0] = 1'b1;
        idle(40);
        check_eq("fstart_rise", 32'(rise_c[0] - s_rise[0]), 32'd0);
        check_eq("fstart_errs", 32'(err_delta(0)), 32'd0);
        check_eq("fstart_busy_short",
                 32'((busy_c[0] - s_busy[0] > 0) && (busy_c[0] - s_busy[0] < CPB)), 32'd1);
        check_eq("fstart_idle", 32'(bsy[0]), 32'd0);

        // Framing error on 0x3C, then good 0x11
        snap();
        drive_frame(0, 16'({1'b0, 8'h3C, 1'b0}), 10, -1, -1);
        idle(20);
        check_eq("frm_fe_cycles", 32'(fe_c[0] - s_fe[0]), 32'd1);
        check_eq("frm_pe", 32'(pe_c[0] - s_pe[0]), 32'd0);
        check_eq("frm_rise", 32'(rise_c[0] - s_rise[0]), 32'd0);
        snap();
        drive_frame(0, 16'({1'b1, 8'h11, 1'b0}), 10, -1, -1);
        idle(20);
        check_eq("after_frm_rise", 32'(rise_c[0] - s_rise[0]), 32'd1);
        check_eq("after_frm_data", 32'(dout_n), 32'h0000_0011);

        // Overrun: ready low, 0x01 then 0x02 back-to-back
        ready[0] = 1'b0;
        snap();
        drive_frame(0, 16'({1'b1, 8'h01, 1'b0}), 10, -1, -1);
        drive_frame(0, 16'({1'b1, 8'h02, 1'b0}), 10, -1, -1);
        idle(20);
        check_eq("ovr_rise", 32'(rise_c[0] - s_rise[0]), 32'd1);
        check_eq("ovr_ov_cycles", 32'(ov_c[0] - s_ov[0]), 32'd1);
        check_eq("ovr_dv_held", 32'(dv[0]), 32'd1);
        check_eq("ovr_data_held", 32'(dout_n), 32'h0000_0001);
        ready[0] = 1'b1;
        idle(1);
        check_eq("ovr_consumed_dv", 32'(dv[0]), 32'd0);
        check_eq("ovr_consumed_data", 32'(dout_n), 32'h0000_0001);

        // 7O2 0x55 (odd parity bit 1) with a glitch on data bit 3 first sample
        ready[2] = 1'b0;
        snap();
        drive_frame(2, 16'({2'b11, 1'b1, 7'h55, 1'b0}), 11, 4, -1);
        idle(20);
        check_eq("glitch_data", 32'(dout_o), 32'h0000_0055);
        check_eq("glitch_dv", 32'(dv[2]), 32'd1);
        check_eq("glitch_errs", 32'(err_delta(2)), 32'd0);

        // Reset in the middle of data bit 4 discards frame and held word
        snap();
        drive_frame(2, 16'({2'b11, 1'b1, 7'h55, 1'b0}), 11, -1, 5);
        idle(60);
        check_eq("post_rst_rise", 32'(rise_c[2] - s_rise[2]), 32'd0);
        check_eq("post_rst_dv", 32'(dv[2]), 32'd0);
        check_eq("post_rst_errs", 32'(err_delta(2)), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised second-generation UART receiver. Supports a configurable data width, optional even/odd parity and 1 or 2 stop bits. Rx is synchronised and majority-voted at mid-bit; start bits are validated, and parity and framing errors are reported. The received word is delivered on a valid/ready handshake with overrun detection. It sits between the board Rx pin and the byte consumer (FIFO or command decoder).

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
CYCLES_PER_BIT, CLOCK_FREQ/BAUD_RATE, clock cycles per bit; must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  reset, synchronous, active-low
enable  in  1  receiver enable
Rx  in  1  asynchronous serial line, idle high
data_out  out  DATA_BITS  received word, LSB = first data bit
data_valid  out  1  data_out holds an unconsumed word
data_ready  in  1  consumer accepts the word when data_valid && data_ready
parity_error  out  1  one-cycle pulse: bad parity, frame dropped
framing_error  out  1  one-cycle pulse: stop bit sampled 0, frame dropped
overrun  out  1  one-cycle pulse: good frame completed while the buffer was full, new frame dropped
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, synchronous, active-low. On the first rising clk edge with nRst=0, every output goes to 0 and the FSM goes to IDLE. The synchroniser flops reset to 1. A reset mid-frame discards the frame and any held word.
- Rx passes through 2 flops (rx_s). All decisions use rx_s.
- Bit timer cnt runs 0..CYCLES_PER_BIT-1 and wraps to 0. HALF = CYCLES_PER_BIT/2.
- Bit sampling: take rx_s at cnt = HALF-1, HALF and HALF+1. The bit value is the 2-of-3 majority, decided at cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s = 0 and the previous rx_s = 1, go to START with cnt = 0.
  - START: at the decision point, majority = 1 is a false start and returns to IDLE with no outputs. Majority = 0 continues. At cnt wrap, go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit wraps, go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: sample one bit. Even parity is OK when XOR(data, p) = 0. Odd parity is OK when XOR(data, p) = 1.
  - STOP: sample STOP_BITS bits. Any 0 stop bit is a framing error. At the decision point of the last stop bit, go straight to IDLE without waiting for the wrap, so a back-to-back start bit is caught.
- Completion, in the cycle after the last stop decision:
  - If framing is bad: pulse framing_error. Framing error takes precedence; parity_error is not pulsed.
  - Else if parity is bad: pulse parity_error.
  - Else if the buffer is free (data_valid = 0, or data_valid && data_ready in that same cycle): load data_out and set data_valid = 1.
  - Else: pulse overrun. data_out and data_valid are unchanged.
- Handshake: data_valid stays high with data_out stable until a cycle with data_ready = 1. data_valid falls on the next edge. A simultaneous accept and new completion replaces the word, data_valid stays 1 and there is no overrun.
- enable = 0: on the next edge the FSM returns to IDLE, any in-progress frame is aborted and no pulses are generated. A held data_out/data_valid is retained and can still be accepted.
- Error pulses are exactly 1 cycle and never coincide with a data_valid rise for the same frame.
- Latency: data_valid rises 2 (sync) + 1 cycles after the last stop-bit decision point on Rx.

Test Plan:
CYCLES_PER_BIT = 16, 8N1, data_ready held 1; send 0xA5 -> data_valid high 1 cycle with data_out = 0xA5, no error pulses; busy falls at the stop decision.
PARITY = 1 (even); send 0x5A with parity bit 1 -> parity_error one pulse, data_valid stays 0. Resend with parity bit 0 -> data_out = 0x5A.
Rx low for 3 cycles, then high -> false start; FSM returns to IDLE, no outputs, busy high for fewer than 16 cycles.
Send 0x3C with the stop bit forced to 0 -> framing_error one pulse, no data_valid. The next good frame, 0x11, is received correctly.
data_ready = 0; send 0x01 then 0x02 back-to-back -> data_valid = 1 with data_out = 0x01, overrun pulses after the second frame. Raise data_ready -> 0x01 is consumed, data_valid falls.
DATA_BITS = 7, PARITY = 2 (odd), STOP_BITS = 2; send 0x55 with a glitch at cnt = HALF-1 of bit 3 -> the majority vote rejects the glitch and data_out = 0x55. Assert nRst = 0 mid-data bit 4 -> all outputs 0 on the next edge and the frame is discarded.
